// File: rtl/pi_bus_bridge.sv
// -----------------------------------------------------------------------------
// pi_bus_bridge
//
// Purpose:
//   Carries one Pi transaction, latched by the SPI command stage, onto the
//   shared RAM bus. The asynchronous pi_pending request is synchronised into
//   the clk domain. The bridge then requests the Pi bus slot and waits for the
//   grant strobe. It performs a single RAM read or write with a strobe that is
//   exactly ACCESS_CYCLES clocks wide. Completion (pi_done, plus pi_data_out
//   for reads) is returned through a four-phase handshake.
//
// Parameters:
//   SYNC_STAGES    flops in the pi_pending synchroniser (>= 2)
//   ACCESS_CYCLES  clocks the RAM strobe is held active (1..15)
//
// Ports:
//   clk, reset_n                 system clock, synchronous active-low reset
//   pi_pending                   async request from the SPI stage
//   pi_rw_b, pi_addr, pi_data_in transaction fields, stable while pending
//   pi_done, pi_data_out         completion flag and read result
//   bus_grant, bus_req           Pi slot strobe in, slot request out
//   ram_addr, ram_data_out       RAM address and write data
//   ram_data_oe                  drive ram_data_out onto the data bus
//   ram_we_n, ram_oe_n           RAM write strobe / output enable (active low)
//   ram_data_in                  RAM read data
// -----------------------------------------------------------------------------
module pi_bus_bridge #(
   parameter int SYNC_STAGES   = 2,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pi_pending,
   input  logic        pi_rw_b,
   input  logic [16:0] pi_addr,
   input  logic [7:0]  pi_data_in,
   output logic        pi_done,
   output logic [7:0]  pi_data_out,
   input  logic        bus_grant,
   output logic        bus_req,
   output logic [16:0] ram_addr,
   output logic [7:0]  ram_data_out,
   output logic        ram_data_oe,
   output logic        ram_we_n,
   output logic        ram_oe_n,
   input  logic [7:0]  ram_data_in
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_GRANT = 2'd1,
      ACCESS     = 2'd2,
      DONE       = 2'd3
   } state_t;

   // The strobe is asserted on the grant edge and is then held for the
   // remaining ACCESS_CYCLES-1 counts. That makes it exactly ACCESS_CYCLES wide.
   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   // ---------------------------------------------------------------- sync chain
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   pend_s;

   assign sync_d[0] = pi_pending;

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign sync_d[gi] = sync_q[gi-1];
      end
   endgenerate

   assign pend_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- registers
   state_t      state_q,        state_d;
   logic        bus_req_q,      bus_req_d;
   logic [16:0] ram_addr_q,     ram_addr_d;
   logic [7:0]  ram_data_out_q, ram_data_out_d;
   logic        ram_data_oe_q,  ram_data_oe_d;
   logic        ram_we_n_q,     ram_we_n_d;
   logic        ram_oe_n_q,     ram_oe_n_d;
   logic        pi_done_q,      pi_done_d;
   logic [7:0]  pi_data_out_q,  pi_data_out_d;
   logic [3:0]  cnt_q,          cnt_d;
   logic [16:0] lat_addr_q,     lat_addr_d;
   logic [7:0]  lat_data_q,     lat_data_d;
   logic        lat_rw_q,       lat_rw_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q         <= '0;
         state_q        <= IDLE;
         bus_req_q      <= 1'b0;
         ram_addr_q     <= '0;
         ram_data_out_q <= '0;
         ram_data_oe_q  <= 1'b0;
         ram_we_n_q     <= 1'b1;
         ram_oe_n_q     <= 1'b1;
         pi_done_q      <= 1'b0;
         pi_data_out_q  <= '0;
         cnt_q          <= '0;
         lat_addr_q     <= '0;
         lat_data_q     <= '0;
         lat_rw_q       <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         state_q        <= state_d;
         bus_req_q      <= bus_req_d;
         ram_addr_q     <= ram_addr_d;
         ram_data_out_q <= ram_data_out_d;
         ram_data_oe_q  <= ram_data_oe_d;
         ram_we_n_q     <= ram_we_n_d;
         ram_oe_n_q     <= ram_oe_n_d;
         pi_done_q      <= pi_done_d;
         pi_data_out_q  <= pi_data_out_d;
         cnt_q          <= cnt_d;
         lat_addr_q     <= lat_addr_d;
         lat_data_q     <= lat_data_d;
         lat_rw_q       <= lat_rw_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d        = state_q;
      bus_req_d      = bus_req_q;
      ram_addr_d     = ram_addr_q;
      ram_data_out_d = ram_data_out_q;
      ram_data_oe_d  = ram_data_oe_q;
      ram_we_n_d     = ram_we_n_q;
      ram_oe_n_d     = ram_oe_n_q;
      pi_done_d      = pi_done_q;
      pi_data_out_d  = pi_data_out_q;
      cnt_d          = cnt_q;
      lat_addr_d     = lat_addr_q;
      lat_data_d     = lat_data_q;
      lat_rw_d       = lat_rw_q;

      case (state_q)
         IDLE: begin
            // Entry to IDLE always follows pend_s low, so a high pend_s here
            // is a fresh request. Its fields are captured once, right now.
            if (pend_s) begin
               state_d    = WAIT_GRANT;
               bus_req_d  = 1'b1;
               lat_addr_d = pi_addr;
               lat_data_d = pi_data_in;
               lat_rw_d   = pi_rw_b;
            end
         end

         WAIT_GRANT: begin
            // An abort is checked first, so a grant on the same edge is dropped.
            if (!pend_s) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
            end else if (bus_grant) begin
               state_d    = ACCESS;
               ram_addr_d = lat_addr_q;
               cnt_d      = CNT_LOAD;
               if (lat_rw_q) begin
                  ram_oe_n_d = 1'b0;
               end else begin
                  ram_data_out_d = lat_data_q;
                  ram_data_oe_d  = 1'b1;
                  ram_we_n_d     = 1'b0;
               end
            end
         end

         ACCESS: begin
            // pend_s is not looked at here. Once started, the access runs to the end.
            if (cnt_q == 4'd0) begin
               state_d    = DONE;
               ram_we_n_d = 1'b1;
               ram_oe_n_d = 1'b1;
               bus_req_d  = 1'b0;
               pi_done_d  = 1'b1;
               if (lat_rw_q) begin
                  pi_data_out_d = ram_data_in;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         DONE: begin
            // After a write the data bus is still driven during the first DONE
            // cycle, which gives hold time after ram_we_n rises.
            ram_data_oe_d = 1'b0;
            if (!pend_s) begin
               state_d   = IDLE;
               pi_done_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign pi_done      = pi_done_q;
   assign pi_data_out  = pi_data_out_q;
   assign bus_req      = bus_req_q;
   assign ram_addr     = ram_addr_q;
   assign ram_data_out = ram_data_out_q;
   assign ram_data_oe  = ram_data_oe_q;
   assign ram_we_n     = ram_we_n_q;
   assign ram_oe_n     = ram_oe_n_q;

endmodule

// File: tb/tb_pi_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_pi_bus_bridge
//
// Directed bench for pi_bus_bridge with default parameters (2 sync stages,
// 2-cycle strobe). Each transaction that should reach the RAM pushes its
// expected strobe (kind, address, data, width, pi_done at strobe end) onto a
// scoreboard. A negedge monitor measures every real strobe and pops from the
// scoreboard to compare.
// -----------------------------------------------------------------------------
module tb_pi_bus_bridge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pi_pending = 1'b0;
   logic        pi_rw_b = 1'b0;
   logic [16:0] pi_addr = '0;
   logic [7:0]  pi_data_in = '0;
   logic        pi_done;
   logic [7:0]  pi_data_out;
   logic        bus_grant = 1'b0;
   logic        bus_req;
   logic [16:0] ram_addr;
   logic [7:0]  ram_data_out;
   logic        ram_data_oe;
   logic        ram_we_n;
   logic        ram_oe_n;
   logic [7:0]  ram_data_in = '0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        is_write;
      logic [16:0] addr;
      logic [7:0]  data;
      int          width;
      logic        done;
   } exp_t;

   exp_t sb_q[$];

   pi_bus_bridge #(
      .SYNC_STAGES  (2),
      .ACCESS_CYCLES(2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pi_pending  (pi_pending),
      .pi_rw_b     (pi_rw_b),
      .pi_addr     (pi_addr),
      .pi_data_in  (pi_data_in),
      .pi_done     (pi_done),
      .pi_data_out (pi_data_out),
      .bus_grant   (bus_grant),
      .bus_req     (bus_req),
      .ram_addr    (ram_addr),
      .ram_data_out(ram_data_out),
      .ram_data_oe (ram_data_oe),
      .ram_we_n    (ram_we_n),
      .ram_oe_n    (ram_oe_n),
      .ram_data_in (ram_data_in)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit exceeded");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic        mon_en = 1'b0;
   int          mon_width = 0;
   logic        mon_we;
   logic [16:0] mon_addr;
   logic [7:0]  mon_data;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("we_oe_both_low", {31'b0, (ram_we_n === 1'b0 && ram_oe_n === 1'b0)}, 32'd0);
         chk("doe_with_oe_low", {31'b0, (ram_data_oe === 1'b1 && ram_oe_n === 1'b0)}, 32'd0);
         if (ram_we_n === 1'b0 || ram_oe_n === 1'b0) begin
            if (mon_width == 0) begin
               mon_we   = (ram_we_n === 1'b0);
               mon_addr = ram_addr;
               mon_data = ram_data_out;
               chk("done_low_at_strobe_start", {31'b0, pi_done}, 32'd0);
            end
            mon_width++;
         end else if (mon_width > 0) begin
            chk("strobe_expected", {31'b0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
               exp_t e;
               e = sb_q.pop_front();
               $display("strobe %s addr=%05h data=%02h width=%0d done=%0b",
                        mon_we ? "WR" : "RD", mon_addr, mon_data, mon_width, pi_done);
               chk("strobe_kind", {31'b0, mon_we}, {31'b0, e.is_write});
               chk("strobe_addr", {15'b0, mon_addr}, {15'b0, e.addr});
               if (e.is_write) chk("strobe_wdata", {24'b0, mon_data}, {24'b0, e.data});
               chk("strobe_width", mon_width, e.width);
               chk("done_at_strobe_end", {31'b0, pi_done}, {31'b0, e.done});
            end
            mon_width = 0;
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic request(input logic rw, input logic [16:0] addr, input logic [7:0] data);
      pi_rw_b    = rw;
      pi_addr    = addr;
      pi_data_in = data;
      pi_pending = 1'b1;
   endtask

   task automatic expect_strobe(input logic is_wr, input logic [16:0] addr,
                                input logic [7:0] data, input int width, input logic done);
      exp_t e;
      e.is_write = is_wr;
      e.addr     = addr;
      e.data     = data;
      e.width    = width;
      e.done     = done;
      sb_q.push_back(e);
   endtask

   // which: 0 = bus_req, 1 = pi_done. Bounded wait at negedges.
   task automatic wait_for(input int which, input logic val, input string tag);
      int   n;
      logic cur;
      n = 0;
      cur = (which == 0) ? bus_req : pi_done;
      while (cur !== val && n < 30) begin
         @(negedge clk);
         n++;
         cur = (which == 0) ? bus_req : pi_done;
      end
      chk(tag, {31'b0, cur}, {31'b0, val});
   endtask

   task automatic pulse_grant();
      bus_grant = 1'b1;
      @(negedge clk);
      bus_grant = 1'b0;
   endtask

   // Complete transaction: request, grant after 'gap' cycles, handshake out.
   task automatic run_xfer(input logic rw, input logic [16:0] addr,
                           input logic [7:0] data, input int gap);
      expect_strobe(!rw, addr, data, 2, 1'b1);
      request(rw, addr, data);
      wait_for(0, 1'b1, "xfer_bus_req");
      repeat (gap - 1) @(negedge clk);
      pulse_grant();
      wait_for(1, 1'b1, "xfer_done_rise");
      if (rw) chk("xfer_rdata", {24'b0, pi_data_out}, {24'b0, ram_data_in});
      pi_pending = 1'b0;
      wait_for(1, 1'b0, "xfer_done_fall");
      $display("xfer %s addr=%05h data=%02h complete", rw ? "RD" : "WR", addr, data);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pi_done", {31'b0, pi_done}, 32'd0);
      chk("rst_pi_data_out", {24'b0, pi_data_out}, 32'd0);
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_ram_addr", {15'b0, ram_addr}, 32'd0);
      chk("rst_ram_data_out", {24'b0, ram_data_out}, 32'd0);
      chk("rst_ram_data_oe", {31'b0, ram_data_oe}, 32'd0);
      chk("rst_ram_we_n", {31'b0, ram_we_n}, 32'd1);
      chk("rst_ram_oe_n", {31'b0, ram_oe_n}, 32'd1);
      $display("reset checked");
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      // Write 08000 <- A5, grant 4 cycles after bus_req, grant noise in DONE
      ram_data_in = 8'hEE;
      expect_strobe(1'b1, 17'h08000, 8'hA5, 2, 1'b1);
      request(1'b0, 17'h08000, 8'hA5);
      wait_for(0, 1'b1, "wr_bus_req");
      chk("wr_no_early_strobe", {31'b0, ram_we_n}, 32'd1);
      repeat (3) @(negedge clk);
      pulse_grant();
      chk("wr_we_n_low", {31'b0, ram_we_n}, 32'd0);
      chk("wr_ram_addr", {15'b0, ram_addr}, 32'h08000);
      chk("wr_ram_data", {24'b0, ram_data_out}, 32'hA5);
      chk("wr_data_oe", {31'b0, ram_data_oe}, 32'd1);
      wait_for(1, 1'b1, "wr_done_rise");
      chk("wr_oe_hold", {31'b0, ram_data_oe}, 32'd1);
      chk("wr_bus_req_off", {31'b0, bus_req}, 32'd0);
      chk("wr_no_rdata", {24'b0, pi_data_out}, 32'd0);
      pulse_grant();
      chk("wr_oe_released", {31'b0, ram_data_oe}, 32'd0);
      chk("done_noise_done", {31'b0, pi_done}, 32'd1);
      chk("done_noise_we_n", {31'b0, ram_we_n}, 32'd1);
      pi_pending = 1'b0;
      @(negedge clk);
      chk("wr_done_held_sync", {31'b0, pi_done}, 32'd1);
      wait_for(1, 1'b0, "wr_done_fall");
      $display("write 08000<-A5 complete");

      // Read 1FFFF, RAM returns 3C
      ram_data_in = 8'h3C;
      expect_strobe(1'b0, 17'h1FFFF, 8'h00, 2, 1'b1);
      request(1'b1, 17'h1FFFF, 8'h00);
      wait_for(0, 1'b1, "rd_bus_req");
      pulse_grant();
      chk("rd_oe_n_low", {31'b0, ram_oe_n}, 32'd0);
      chk("rd_we_n_high", {31'b0, ram_we_n}, 32'd1);
      chk("rd_data_oe_off", {31'b0, ram_data_oe}, 32'd0);
      chk("rd_ram_addr", {15'b0, ram_addr}, 32'h1FFFF);
      wait_for(1, 1'b1, "rd_done_rise");
      chk("rd_data", {24'b0, pi_data_out}, 32'h3C);
      ram_data_in = 8'h99;
      repeat (2) @(negedge clk);
      chk("rd_data_held", {24'b0, pi_data_out}, 32'h3C);
      chk("rd_done_held", {31'b0, pi_done}, 32'd1);
      pi_pending = 1'b0;
      wait_for(1, 1'b0, "rd_done_fall");
      $display("read 1FFFF -> 3C complete");

      // Abort in WAIT_GRANT, then grant noise in IDLE
      request(1'b0, 17'h00123, 8'h77);
      wait_for(0, 1'b1, "ab_bus_req");
      @(negedge clk);
      pi_pending = 1'b0;
      wait_for(0, 1'b0, "ab_bus_req_fall");
      chk("ab_no_done", {31'b0, pi_done}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         pulse_grant();
         @(negedge clk);
         chk("idle_noise_bus_req", {31'b0, bus_req}, 32'd0);
      end
      $display("abort before grant complete");

      // Abort coinciding with a grant: abort must win
      request(1'b0, 17'h00124, 8'h66);
      wait_for(0, 1'b1, "abg_bus_req");
      pi_pending = 1'b0;
      @(negedge clk);
      @(negedge clk);
      pulse_grant();
      chk("abg_bus_req_off", {31'b0, bus_req}, 32'd0);
      chk("abg_no_strobe", {31'b0, ram_we_n}, 32'd1);
      repeat (3) @(negedge clk);
      chk("abg_no_done", {31'b0, pi_done}, 32'd0);
      $display("abort with coincident grant complete");

      // Reset in the middle of a write strobe
      expect_strobe(1'b1, 17'h00400, 8'h5A, 1, 1'b0);
      request(1'b0, 17'h00400, 8'h5A);
      wait_for(0, 1'b1, "rst_mid_bus_req");
      pulse_grant();
      chk("rst_mid_we_n_low", {31'b0, ram_we_n}, 32'd0);
      reset_n    = 1'b0;
      pi_pending = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_mid_we_n", {31'b0, ram_we_n}, 32'd1);
      chk("rst_mid_data_oe", {31'b0, ram_data_oe}, 32'd0);
      chk("rst_mid_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_mid_done", {31'b0, pi_done}, 32'd0);
      repeat (3) @(negedge clk);
      $display("reset mid-access complete");
      run_xfer(1'b0, 17'h00401, 8'hC3, 2);

      // Back-to-back writes
      run_xfer(1'b0, 17'h00010, 8'h11, 1);
      run_xfer(1'b0, 17'h00011, 8'h22, 3);

      // A read through the generic path as well
      ram_data_in = 8'h5E;
      run_xfer(1'b1, 17'h0ABCD, 8'h00, 2);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pi_bus_bridge.md
Name: pi_bus_bridge

Overview:
- Downstream consumer of the Pi SPI command stage. It takes the latched Pi transaction (addr, data, rw_b, pending) from the SPI clock domain and synchronizes pending into the system clock domain.
- It waits for the Pi bus slot, performs one RAM read or write, and returns done plus read data through a four-phase handshake.
- It sits between the SPI command decoder and the shared 128 KiB RAM bus arbitration.

Parameters:
- SYNC_STAGES, 2, flops in pending synchronizer (min 2).
- ACCESS_CYCLES, 2, clk cycles RAM strobe held active (min 1, max 15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- pi_pending  in  1  async request from SPI stage; high = transaction valid.
- pi_rw_b  in  1  1 = read, 0 = write; stable while pi_pending high.
- pi_addr  in  17  target address; stable while pi_pending high.
- pi_data_in  in  8  write data; stable while pi_pending high.
- pi_done  out  1  transaction complete; returned to SPI stage.
- pi_data_out  out  8  read result; valid while pi_done high.
- bus_grant  in  1  one-cycle strobe from timing generator marking the Pi slot.
- bus_req  out  1  request for the Pi slot.
- ram_addr  out  17  RAM address.
- ram_data_out  out  8  RAM write data.
- ram_data_oe  out  1  drive ram_data_out onto bus.
- ram_we_n  out  1  RAM write strobe, active low.
- ram_oe_n  out  1  RAM output enable, active low.
- ram_data_in  in  8  RAM read data.

Behaviour:
- Reset (reset_n low at posedge clk):
  - state = IDLE; sync chain cleared.
  - pi_done = 0, pi_data_out = 0, bus_req = 0.
  - ram_addr = 0, ram_data_out = 0, ram_data_oe = 0, ram_we_n = 1, ram_oe_n = 1.
- Synchronizer: pend_s = pi_pending delayed SYNC_STAGES flops. Only pend_s is used by the FSM.
- Capture: on IDLE→WAIT_GRANT, latch pi_addr, pi_data_in and pi_rw_b into internal regs. These inputs are not sampled afterwards.
- IDLE:
  - pend_s = 1 → WAIT_GRANT, with bus_req = 1 from the next cycle.
- WAIT_GRANT:
  - Hold bus_req = 1.
  - bus_grant = 1 → ACCESS. On the same edge drive ram_addr = latched addr, and load the cycle counter with ACCESS_CYCLES-1.
  - Write: ram_data_out = latched data, ram_data_oe = 1, ram_we_n = 0.
  - Read: ram_oe_n = 0.
  - pend_s falling here (aborted request) → IDLE with bus_req = 0 and no RAM access.
- ACCESS:
  - Counter decrements each cycle.
  - At counter 0 → DONE. On that edge:
    - Read: pi_data_out <= ram_data_in.
    - ram_we_n = 1, ram_oe_n = 1, bus_req = 0, pi_done = 1.
    - ram_data_oe stays 1 for one extra cycle (write hold), then 0.
  - pend_s falling during ACCESS is ignored; the access always completes.
- DONE:
  - Hold pi_done = 1 and pi_data_out until pend_s = 0.
  - Then pi_done = 0 → IDLE.
  - A new request cannot start until pend_s has been seen low for at least one cycle.
- Latency, pi_pending rise to strobe active: SYNC_STAGES + 1 + (cycles to grant) clk.
  - Strobe width = ACCESS_CYCLES clk exactly.
  - pi_done rises on the edge that ends the strobe.
- bus_grant outside WAIT_GRANT is ignored. bus_grant coinciding with the pend_s fall in WAIT_GRANT → abort wins, no access.
- ram_we_n and ram_oe_n are never both 0. ram_data_oe = 1 is never combined with ram_oe_n = 0.
- Reset mid-ACCESS: all strobes deassert on that edge, no pi_done. The SPI stage recovers via its own reset path.
- Address 17'h1FFFF is valid; there is no wrap logic and the address is passed through unchanged.

Test Plan:
- Write: addr=17'h08000, data=8'hA5, rw_b=0; grant 4 cycles after bus_req.
  - ram_we_n low exactly 2 clk with ram_addr=08000, ram_data_out=A5.
  - pi_done rises at strobe end and falls 2 clk after pi_pending drops.
- Read: addr=17'h1FFFF, rw_b=1, ram_data_in=8'h3C.
  - ram_oe_n low 2 clk, ram_we_n stays 1, pi_data_out=3C while pi_done=1.
- Abort: pi_pending drops in WAIT_GRANT before any grant.
  - bus_req falls, no strobe, pi_done stays 0, FSM back in IDLE.
- Grant noise: bus_grant pulses while in IDLE and DONE.
  - No RAM strobe, no state change.
- Reset mid-ACCESS (write): reset_n low 1 clk.
  - ram_we_n=1, ram_data_oe=0, bus_req=0, pi_done=0 on the next edge.
  - A following request completes normally.
- Back-to-back: two writes (0x00010←0x11, 0x00011←0x22) with pending low between them.
  - Two distinct strobes; the second starts only after pi_done has cleared.
